// File: rtl/if_prefetch_queue.sv
// rtl/if_prefetch_queue.sv - instruction fetch unit with credit-controlled prefetch queue
module if_prefetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       br,
    input  logic [ADDR_W-1:0]          br_target,
    output logic                       mem_re,
    output logic [ADDR_W-1:0]          mem_addr_o,
    input  logic                       mem_busy,
    input  logic                       mem_done,
    input  logic [INST_W-1:0]          mem_data_i,
    input  logic                       id_ready,
    output logic                       inst_valid,
    output logic [ADDR_W-1:0]          pc_o,
    output logic [INST_W-1:0]          inst_o,
    output logic                       stallreq,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);
    localparam int                CNT_W = $clog2(DEPTH + 1);
    localparam int                PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              push;
    logic              pop;

    // A redirect kills both the pop and the push of the same cycle.
    assign pop  = inst_valid && id_ready && !br;
    assign push = (state == WAIT) && mem_done && !br;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    assign q_count  = count;
    assign stallreq = !inst_valid;
    assign pc_o     = inst_valid ? pc_mem[rd_ptr]   : '0;
    assign inst_o   = inst_valid ? inst_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            inst_mem[wr_ptr] <= mem_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            inst_valid <= 1'b0;
            mem_re     <= 1'b0;
            mem_addr_o <= '0;
        end else begin
            if (br) begin
                count      <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                inst_valid <= 1'b0;
                fetch_pc   <= br_target;
            end else begin
                count      <= count_next;
                inst_valid <= (count_next != '0);
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (push) begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    fetch_pc <= fetch_pc + STEP;
                end
            end

            case (state)
                IDLE: begin
                    if (!br && count < FULL) begin
                        state      <= REQ;
                        mem_re     <= 1'b1;
                        mem_addr_o <= fetch_pc;
                    end
                end
                REQ: begin
                    if (!mem_busy) begin
                        mem_re <= 1'b0;
                        state  <= br ? DROP : WAIT;
                    end else if (br) begin
                        mem_re <= 1'b0;
                        state  <= IDLE;
                    end
                end
                WAIT: begin
                    if (br) begin
                        state <= mem_done ? IDLE : DROP;
                    end else if (mem_done) begin
                        // Chain the next read immediately while a slot is still free.
                        if (count_next < FULL) begin
                            state      <= REQ;
                            mem_re     <= 1'b1;
                            mem_addr_o <= fetch_pc + STEP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (mem_done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && !pop && count == FULL));
            assert (!(pop && count == '0));
        end
    end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb/tb_if_prefetch_queue.sv - self-checking bench for if_prefetch_queue
module tb_if_prefetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n, br, mem_busy, mem_done, id_ready;
    logic [31:0] br_target, mem_data_i;
    logic        mem_re, inst_valid, stallreq;
    logic [31:0] mem_addr_o, pc_o, inst_o;
    logic [2:0]  q_count;

    if_prefetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .PC_STEP(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .br(br), .br_target(br_target),
        .mem_re(mem_re), .mem_addr_o(mem_addr_o), .mem_busy(mem_busy),
        .mem_done(mem_done), .mem_data_i(mem_data_i), .id_ready(id_ready),
        .inst_valid(inst_valid), .pc_o(pc_o), .inst_o(inst_o),
        .stallreq(stallreq), .q_count(q_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    int          outs;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_acc = 0;
    int          n_pop = 0;
    logic [31:0] last_acc_addr;
    bit          rsp_busy = 0;
    int          rsp_lat = 0;
    int          lat_cfg = 1;
    logic [31:0] rsp_addr;

    function automatic logic [31:0] data_of(logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic        acc, dn, hold, b2b;
        logic [31:0] pre_addr;
        int          outs_pre;
        mem_done   = 1'b0;
        mem_data_i = $urandom();
        if (rsp_busy && rsp_lat == 0) begin
            mem_done   = 1'b1;
            mem_data_i = data_of(rsp_addr);
        end
        acc      = mem_re === 1'b1 && !mem_busy;
        dn       = mem_done;
        hold     = rst_n && mem_re === 1'b1 && mem_busy && !br;
        pre_addr = mem_addr_o;
        outs_pre = outs;
        b2b      = rst_n && !br && dn && outs_pre == 1;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_pc = 32'h0;
            outs = 0;
        end else begin
            if (acc) begin
                n_acc++;
                last_acc_addr = pre_addr;
                chk("acc_addr", pre_addr, m_pc);
                chk("acc_credit", (outs == 0 && mq.size() < DEPTH), 1);
            end
            if (br) begin
                mq.delete();
                m_pc = br_target;
                outs = acc ? 2 : (dn ? 0 : (outs == 1 ? 2 : outs));
            end else begin
                if (id_ready && mq.size() > 0) begin
                    void'(mq.pop_front());
                    n_pop++;
                end
                if (dn && outs == 1) begin
                    mq.push_back({m_pc, mem_data_i});
                    m_pc = m_pc + 32'd4;
                end
                if (dn) outs = 0;
                if (acc) outs = 1;
            end
        end
        if (dn) rsp_busy = 0;
        else if (rsp_busy) rsp_lat--;
        if (acc) begin
            rsp_busy = 1;
            rsp_lat  = lat_cfg;
            rsp_addr = pre_addr;
        end
        #1;
        chk("q_count", q_count, mq.size());
        chk("inst_valid", inst_valid, mq.size() != 0);
        chk("stallreq", stallreq, mq.size() == 0);
        chk("pc_o", pc_o, mq.size() != 0 ? mq[0].pc : 32'h0);
        chk("inst_o", inst_o, mq.size() != 0 ? mq[0].inst : 32'h0);
        if (hold) begin
            chk("hold_re", mem_re, 1);
            chk("hold_addr", mem_addr_o, pre_addr);
        end
        if (b2b) begin
            chk("b2b_re", mem_re, mq.size() < DEPTH);
            if (mq.size() < DEPTH) chk("b2b_addr", mem_addr_o, m_pc);
        end
    endtask

    initial begin
        int a0, s0, guard;
        rst_n = 0; br = 0; br_target = 0; mem_busy = 0; id_ready = 0;
        mem_done = 0; mem_data_i = 0;
        m_pc = 0; outs = 0;
        step(); step();
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_addr", mem_addr_o, 0);

        // 1: sequential streaming
        rst_n = 1; id_ready = 1; lat_cfg = 1;
        step();
        chk("t1_first_re", mem_re, 1);
        chk("t1_first_addr", mem_addr_o, 32'h0);
        repeat (30) step();
        chk("t1_pops", n_pop >= 5, 1);

        // 2: fill to credit limit
        id_ready = 0;
        a0 = n_acc;
        s0 = mq.size() + (outs == 1 ? 1 : 0);
        repeat (25) step();
        chk("t2_reads", n_acc - a0, 4 - s0);
        chk("t2_full", q_count, 4);
        chk("t2_re_idle", mem_re, 0);
        a0 = n_acc;
        id_ready = 1; step();
        id_ready = 0;
        repeat (15) step();
        chk("t2_one_more", n_acc - a0, 1);
        chk("t2_refull", q_count, 4);

        // 3: busy memory holds the request
        mem_busy = 1; id_ready = 1; step();
        id_ready = 0; step();
        chk("t3_req", mem_re, 1);
        a0 = n_acc;
        repeat (5) begin
            step();
            chk("t3_held", mem_re, 1);
        end
        chk("t3_no_acc", n_acc - a0, 0);
        mem_busy = 0; step();
        chk("t3_acc", n_acc - a0, 1);
        chk("t3_re_drop", mem_re, 0);
        repeat (5) step();

        // 4: redirect while a read is in flight
        id_ready = 1; lat_cfg = 3; guard = 0;
        while (outs != 1 && guard < 50) begin step(); guard++; end
        chk("t4_in_wait", outs, 1);
        br = 1; br_target = 32'h100; step();
        br = 0; id_ready = 0;
        chk("t4_flush", q_count, 0);
        a0 = n_acc; guard = 0;
        while (n_acc == a0 && guard < 50) begin step(); guard++; end
        chk("t4_target", last_acc_addr, 32'h100);
        chk("t4_q_empty", q_count, 0);

        // 5: redirect coincides with mem_done and a pop at count 3
        lat_cfg = 1; guard = 0;
        while (!(mq.size() == 3 && outs == 1 && rsp_busy && rsp_lat == 0) && guard < 60) begin
            step(); guard++;
        end
        chk("t5_count3", q_count, 3);
        br = 1; br_target = 32'h200; id_ready = 1; step();
        br = 0; id_ready = 0;
        chk("t5_flush", q_count, 0);
        a0 = n_acc; guard = 0;
        while (n_acc == a0 && guard < 50) begin step(); guard++; end
        chk("t5_target", last_acc_addr, 32'h200);

        // 6: reset during an outstanding read
        id_ready = 1; lat_cfg = 2; guard = 0;
        repeat (3) step();
        while (outs != 1 && guard < 50) begin step(); guard++; end
        chk("t6_in_wait", outs, 1);
        rst_n = 0; step();
        chk("t6_mem_re", mem_re, 0);
        chk("t6_mem_addr", mem_addr_o, 0);
        chk("t6_inst_valid", inst_valid, 0);
        chk("t6_pc_o", pc_o, 0);
        chk("t6_inst_o", inst_o, 0);
        chk("t6_stallreq", stallreq, 1);
        chk("t6_q_count", q_count, 0);
        rst_n = 1;
        a0 = n_acc; guard = 0;
        while (n_acc == a0 && guard < 50) begin step(); guard++; end
        chk("t6_restart", last_acc_addr, 32'h0);
        repeat (10) step();

        // random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            mem_busy  = ($urandom_range(0, 9) < 3);
            id_ready  = ($urandom_range(0, 9) < 6);
            br        = ($urandom_range(0, 19) == 0);
            br_target = {22'h0, $urandom_range(0, 255), 2'b00};
            lat_cfg   = $urandom_range(0, 3);
            step();
        end
        br = 0;
        chk("rand_progress", n_acc > 100, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
